// File: rtl/mii_tx_frame_drain.sv
// mii_tx_frame_drain
//   Drains frames from the egress sync FIFO onto an MII transmit interface.
//   Each FIFO entry is {eof, byte}. A frame goes out as preamble nibbles (0x5),
//   the SFD nibble (0xD), then every data byte low nibble first. An inter-frame
//   gap follows. If the FIFO runs dry mid-frame, or the frame grows longer than
//   MAX_BYTES, one tx_er cycle is sent. The rest of that frame is then popped
//   and discarded up to its eof entry.
//
// Ports
//   clk         MII TX clock, one nibble per cycle
//   rst_n       asynchronous active-low reset
//   fifo_dout   FIFO read data {eof, byte}, valid the cycle after fifo_ren
//   fifo_empty  FIFO empty flag
//   fifo_ren    FIFO pop strobe (combinational, never asserted while empty)
//   mii_txd     transmit nibble (registered)
//   mii_tx_en   transmit enable (registered)
//   mii_tx_er   transmit error (registered)
//   busy        high while a frame, abort, drop or gap is in progress
//   frame_done  one-cycle pulse with the last data nibble of a clean frame
//   underrun    one-cycle pulse with the error nibble (underrun or jabber)
module mii_tx_frame_drain #(
    parameter int PRE_NIBBLES = 15,
    parameter int IFG_NIBBLES = 24,
    parameter int MAX_BYTES   = 1518
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_ren,
    output logic [3:0] mii_txd,
    output logic       mii_tx_en,
    output logic       mii_tx_er,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_ERR,
        S_DROP,
        S_IFG
    } state_t;

    // The preamble counter runs 0..PRE_NIBBLES. The last count is the SFD nibble.
    localparam logic [4:0]  PRE_LAST = 5'(PRE_NIBBLES - 1);
    localparam logic [4:0]  SFD_NIB  = 5'(PRE_NIBBLES);
    // The IDLE cycle that follows IFG is itself an idle nibble on the wire.
    // IFG therefore lasts IFG_NIBBLES-1 cycles. This is also why IFG_NIBBLES
    // must be at least 2.
    localparam logic [4:0]  IFG_LAST = 5'(IFG_NIBBLES - 2);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_BYTES);

    state_t      state_reg,    state_next;
    logic [4:0]  nib_cnt_reg,  nib_cnt_next;
    logic [4:0]  ifg_cnt_reg,  ifg_cnt_next;
    logic [10:0] byte_cnt_reg, byte_cnt_next;
    logic        phase_reg,    phase_next;
    logic        pend_reg,     pend_next;      // a read issued last cycle returns now
    logic        cur_eof_reg,  cur_eof_next;
    logic [7:0]  cur_byte_reg, cur_byte_next;
    logic        last_eof_reg, last_eof_next;  // eof flag of the most recently fetched entry

    logic [3:0]  txd_c;
    logic        tx_en_c;
    logic        tx_er_c;
    logic        done_c;
    logic        under_c;
    logic        ren_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            nib_cnt_reg  <= '0;
            ifg_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            phase_reg    <= 1'b0;
            pend_reg     <= 1'b0;
            cur_eof_reg  <= 1'b0;
            cur_byte_reg <= '0;
            last_eof_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            nib_cnt_reg  <= nib_cnt_next;
            ifg_cnt_reg  <= ifg_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            phase_reg    <= phase_next;
            pend_reg     <= pend_next;
            cur_eof_reg  <= cur_eof_next;
            cur_byte_reg <= cur_byte_next;
            last_eof_reg <= last_eof_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        nib_cnt_next  = nib_cnt_reg;
        ifg_cnt_next  = ifg_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        phase_next    = phase_reg;
        pend_next     = pend_reg;
        cur_eof_next  = cur_eof_reg;
        cur_byte_next = cur_byte_reg;
        last_eof_next = last_eof_reg;
        txd_c         = 4'h0;
        tx_en_c       = 1'b0;
        tx_er_c       = 1'b0;
        done_c        = 1'b0;
        under_c       = 1'b0;
        ren_c         = 1'b0;

        case (state_reg)
            S_IDLE: begin
                pend_next = 1'b0;
                if (!fifo_empty) begin
                    state_next   = S_PRE;
                    nib_cnt_next = '0;
                end
            end

            S_PRE: begin
                tx_en_c = 1'b1;
                txd_c   = (nib_cnt_reg == SFD_NIB) ? 4'hD : 4'h5;
                if (nib_cnt_reg == PRE_LAST) begin
                    // Prefetch the first byte so that it is ready after the SFD.
                    ren_c         = !fifo_empty;
                    pend_next     = !fifo_empty;
                    last_eof_next = 1'b0;
                end
                if (nib_cnt_reg == SFD_NIB) begin
                    pend_next = 1'b0;
                    if (pend_reg) begin
                        cur_eof_next  = fifo_dout[8];
                        cur_byte_next = fifo_dout[7:0];
                        last_eof_next = fifo_dout[8];
                        byte_cnt_next = 11'd1;
                        phase_next    = 1'b0;
                        state_next    = S_DATA;
                    end else begin
                        state_next = S_ERR;
                    end
                end else begin
                    nib_cnt_next = nib_cnt_reg + 5'd1;
                end
            end

            S_DATA: begin
                tx_en_c = 1'b1;
                if (!phase_reg) begin
                    txd_c      = cur_byte_reg[3:0];
                    phase_next = 1'b1;
                    // Fetch the next byte during the low nibble. It returns
                    // in time for the high-nibble decision.
                    if (!cur_eof_reg && !fifo_empty) begin
                        ren_c     = 1'b1;
                        pend_next = 1'b1;
                    end else begin
                        pend_next = 1'b0;
                    end
                end else begin
                    txd_c     = cur_byte_reg[7:4];
                    pend_next = 1'b0;
                    if (cur_eof_reg) begin
                        done_c       = 1'b1;
                        ifg_cnt_next = '0;
                        state_next   = S_IFG;
                    end else if (pend_reg) begin
                        last_eof_next = fifo_dout[8];
                        if (byte_cnt_reg >= MAX_CNT) begin
                            // Jabber: the fetched byte is already popped, so it
                            // counts as consumed even though it is never sent.
                            state_next = S_ERR;
                        end else begin
                            cur_eof_next  = fifo_dout[8];
                            cur_byte_next = fifo_dout[7:0];
                            byte_cnt_next = byte_cnt_reg + 11'd1;
                            phase_next    = 1'b0;
                        end
                    end else begin
                        last_eof_next = cur_eof_reg;
                        state_next    = S_ERR;
                    end
                end
            end

            S_ERR: begin
                tx_en_c      = 1'b1;
                tx_er_c      = 1'b1;
                under_c      = 1'b1;
                pend_next    = 1'b0;
                ifg_cnt_next = '0;
                state_next   = last_eof_reg ? S_IFG : S_DROP;
            end

            S_DROP: begin
                if (pend_reg && fifo_dout[8]) begin
                    pend_next    = 1'b0;
                    ifg_cnt_next = '0;
                    state_next   = S_IFG;
                end else begin
                    // At most one read is outstanding. Each returned entry is
                    // inspected in the cycle in which the next pop is issued.
                    ren_c     = !fifo_empty;
                    pend_next = !fifo_empty;
                end
            end

            S_IFG: begin
                if (ifg_cnt_reg >= IFG_LAST) begin
                    state_next = S_IDLE;
                end else begin
                    ifg_cnt_next = ifg_cnt_reg + 5'd1;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign fifo_ren = ren_c;

    // Output stage: the wire sees the nibble chosen for the previous state cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mii_txd    <= 4'h0;
            mii_tx_en  <= 1'b0;
            mii_tx_er  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            mii_txd    <= txd_c;
            mii_tx_en  <= tx_en_c;
            mii_tx_er  <= tx_er_c;
            busy       <= (state_reg != S_IDLE);
            frame_done <= done_c;
            underrun   <= under_c;
        end
    end

endmodule
